// File: rtl/kf_pkg.sv
// Shared definitions for the Kalman-filter init/measurement receive path:
// word geometry, coefficient bank index map and the sign-magnitude converter.
package kf_pkg;

  localparam int unsigned W     = 24;
  localparam int unsigned FRAC  = 14;
  localparam int unsigned NCOEF = 20;

  // Coefficient bank index map, in stream order
  localparam int unsigned KF_X1    = 0;
  localparam int unsigned KF_X2    = 1;
  localparam int unsigned KF_P11   = 2;
  localparam int unsigned KF_P12   = 3;
  localparam int unsigned KF_P21   = 4;
  localparam int unsigned KF_P22   = 5;
  localparam int unsigned KF_PHI11 = 6;
  localparam int unsigned KF_PHI12 = 7;
  localparam int unsigned KF_PHI21 = 8;
  localparam int unsigned KF_PHI22 = 9;
  localparam int unsigned KF_Q11   = 10;
  localparam int unsigned KF_Q12   = 11;
  localparam int unsigned KF_Q21   = 12;
  localparam int unsigned KF_Q22   = 13;
  localparam int unsigned KF_H1    = 14;
  localparam int unsigned KF_H2    = 15;
  localparam int unsigned KF_R     = 16;
  localparam int unsigned KF_G1    = 17;
  localparam int unsigned KF_G2    = 18;
  localparam int unsigned KF_U     = 19;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } kf_state_e;

  // Sign-magnitude to two's complement; negative zero maps to 0 naturally
  function automatic logic [W-1:0] sm2tc(input logic [W-1:0] sm);
    logic [W-1:0] mag;
    mag = {1'b0, sm[W-2:0]};
    return sm[W-1] ? (~mag + W'(1)) : mag;
  endfunction

endpackage

// File: rtl/kf_coef_bank.sv
// Coefficient register file: one write port, registered read port,
// out-of-range reads return 0.
module kf_coef_bank #(
  parameter int unsigned W     = 24,
  parameter int unsigned NCOEF = 20,
  parameter int unsigned ADDRW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [ADDRW-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] mem [NCOEF];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCOEF; i++) begin
        mem[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (wr_en && (wr_addr < ADDRW'(NCOEF))) begin
        mem[wr_addr] <= wr_data;
      end
      // Read sees the pre-edge contents; a same-edge write shows up one read later
      rd_data <= (rd_addr < ADDRW'(NCOEF)) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: rtl/kf_init_rx.sv
// Receive endpoint for the KF init/measurement stream: loads NCOEF coefficients
// after START, then latches measurement words on request from the datapath.
module kf_init_rx #(
  parameter int unsigned W     = kf_pkg::W,
  parameter int unsigned FRAC  = kf_pkg::FRAC,
  parameter int unsigned NCOEF = kf_pkg::NCOEF,
  parameter int unsigned ADDRW = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic [W-1:0]     DATA_IN,
  input  logic             meas_take,
  input  logic [ADDRW-1:0] coef_addr,
  output logic [W-1:0]     coef_data,
  output logic             load_done,
  output logic [W-1:0]     meas_data,
  output logic             meas_valid,
  output logic             load_busy
);

  import kf_pkg::*;

  // Counter must reach NCOEF+1, the edge that takes the first measurement
  localparam int unsigned CNTW = $clog2(NCOEF + 2);

  if (W != kf_pkg::W) begin : g_bad_w
    $error("kf_init_rx: W must match kf_pkg::W");
  end
  if ((2 ** ADDRW) < NCOEF) begin : g_bad_addrw
    $error("kf_init_rx: ADDRW too narrow for NCOEF");
  end
  if (FRAC >= W) begin : g_bad_frac
    $error("kf_init_rx: FRAC must be below W");
  end
  if (NCOEF != (KF_U + 1)) begin : g_bad_ncoef
    $error("kf_init_rx: NCOEF must match the coefficient index map");
  end

  kf_state_e        state;
  logic [CNTW-1:0]  cnt;
  logic             wr_en_c;
  logic [ADDRW-1:0] wr_addr_c;
  logic [W-1:0]     conv_c;

  assign conv_c = sm2tc(DATA_IN);

  // Word cnt lands in bank[cnt-1]; a restarting START suppresses the write
  always_comb begin
    wr_en_c   = 1'b0;
    wr_addr_c = ADDRW'(cnt - CNTW'(1));
    if ((state == ST_LOAD) && !START && (cnt != '0) && (cnt <= CNTW'(NCOEF))) begin
      wr_en_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      load_done  <= 1'b0;
      meas_data  <= '0;
      meas_valid <= 1'b0;
      load_busy  <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            state     <= ST_LOAD;
            cnt       <= CNTW'(1);
            load_done <= 1'b0;
            load_busy <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (START) begin
            cnt <= CNTW'(1);
          end else if (cnt == CNTW'(NCOEF + 1)) begin
            state      <= ST_RUN;
            meas_data  <= conv_c;
            meas_valid <= 1'b1;
            load_done  <= 1'b1;
            load_busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNTW'(1);
          end
        end
        ST_RUN: begin
          // START wins over a same-cycle meas_take
          if (START) begin
            state     <= ST_LOAD;
            cnt       <= CNTW'(1);
            load_done <= 1'b0;
            load_busy <= 1'b1;
          end else if (meas_take) begin
            meas_data  <= conv_c;
            meas_valid <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cnt       <= '0;
          load_done <= 1'b0;
          load_busy <= 1'b0;
        end
      endcase
    end
  end

  kf_coef_bank #(
    .W     (W),
    .NCOEF (NCOEF),
    .ADDRW (ADDRW)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_c),
    .wr_addr (wr_addr_c),
    .wr_data (conv_c),
    .rd_addr (coef_addr),
    .rd_data (coef_data)
  );

endmodule

// File: tb/tb_kf_init_rx.sv
// Self-checking bench for kf_init_rx: constant vector table, directed corner
// sequences and random traffic against a word-level reference model.
module tb_kf_init_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [23:0] data_in = '0;
  logic        meas_take = 1'b0;
  logic [4:0]  coef_addr = '0;
  logic [23:0] coef_data;
  logic        load_done;
  logic [23:0] meas_data;
  logic        meas_valid;
  logic        load_busy;

  int n_cmp = 0;
  int n_err = 0;

  kf_init_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .START      (start),
    .DATA_IN    (data_in),
    .meas_take  (meas_take),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .load_done  (load_done),
    .meas_data  (meas_data),
    .meas_valid (meas_valid),
    .load_busy  (load_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Reference model state: what a loaded/loading receiver must hold
  bit          m_loading, m_done, m_mv;
  int          m_seen;
  logic [23:0] m_meas, m_coef;
  logic [23:0] m_bank [20];

  function automatic logic [23:0] ref_conv(input logic [23:0] v);
    int mag;
    mag = int'(v[22:0]);
    return v[23] ? 24'(0 - mag) : v;
  endfunction

  task automatic model_clear();
    m_loading = 1'b0; m_done = 1'b0; m_mv = 1'b0; m_seen = 0;
    m_meas = '0; m_coef = '0;
    for (int i = 0; i < 20; i++) m_bank[i] = '0;
  endtask

  task automatic model_step(input bit s, input logic [23:0] d, input bit t, input logic [4:0] a);
    m_coef = (int'(a) < 20) ? m_bank[a] : 24'h0;
    if (s) begin
      m_loading = 1'b1; m_seen = 0; m_done = 1'b0; m_mv = 1'b0;
    end else if (m_loading) begin
      m_mv = 1'b0;
      if (m_seen < 20) begin
        m_bank[m_seen] = ref_conv(d);
        m_seen++;
      end else begin
        m_meas = ref_conv(d); m_mv = 1'b1; m_done = 1'b1; m_loading = 1'b0;
      end
    end else if (m_done && t) begin
      m_meas = ref_conv(d); m_mv = 1'b1;
    end else begin
      m_mv = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance model, compare every output after the edge
  task automatic cyc(input bit s, input logic [23:0] d, input bit t, input logic [4:0] a);
    start = s; data_in = d; meas_take = t; coef_addr = a;
    model_step(s, d, t, a);
    @(posedge clk); #1;
    chk("m_coef_data", 32'(coef_data), 32'(m_coef));
    chk("m_load_done", 32'(load_done), 32'(m_done));
    chk("m_meas_data", 32'(meas_data), 32'(m_meas));
    chk("m_meas_valid", 32'(meas_valid), 32'(m_mv));
    chk("m_load_busy", 32'(load_busy), 32'(m_loading));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_clear();
    #2;
    chk("rst_coef_data", 32'(coef_data), 32'h0);
    chk("rst_load_done", 32'(load_done), 32'h0);
    chk("rst_meas_data", 32'(meas_data), 32'h0);
    chk("rst_meas_valid", 32'(meas_valid), 32'h0);
    chk("rst_load_busy", 32'(load_busy), 32'h0);
    start = 1'b0; meas_take = 1'b0; data_in = '0; coef_addr = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          s;
    logic [23:0] d;
    bit          t;
    logic [4:0]  a;
    bit          ck_coef;
    logic [23:0] coef;
    bit          done;
    bit          mv;
    logic [23:0] meas;
    bit          busy;
  } vec_t;

  function automatic vec_t mkv(input bit s, input logic [23:0] d, input bit t, input logic [4:0] a,
                               input bit ck, input logic [23:0] coef, input bit done,
                               input bit mv, input logic [23:0] meas, input bit busy);
    vec_t v;
    v.s = s; v.d = d; v.t = t; v.a = a; v.ck_coef = ck; v.coef = coef;
    v.done = done; v.mv = mv; v.meas = meas; v.busy = busy;
    return v;
  endfunction

  logic [23:0] nom [20];
  logic [23:0] ws [20];
  vec_t        tbl [27];

  task automatic run_table();
    for (int i = 0; i < 27; i++) begin
      cyc(tbl[i].s, tbl[i].d, tbl[i].t, tbl[i].a);
      if (tbl[i].ck_coef) chk($sformatf("tbl%0d_coef", i), 32'(coef_data), 32'(tbl[i].coef));
      chk($sformatf("tbl%0d_done", i), 32'(load_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_mv", i), 32'(meas_valid), 32'(tbl[i].mv));
      chk($sformatf("tbl%0d_meas", i), 32'(meas_data), 32'(tbl[i].meas));
      chk($sformatf("tbl%0d_busy", i), 32'(load_busy), 32'(tbl[i].busy));
    end
  endtask

  // 20 words from ws then one measurement word; START issued by the caller
  task automatic load_body(input logic [23:0] meas);
    for (int i = 0; i < 20; i++) cyc(1'b0, ws[i], 1'b0, 5'd0);
    chk("body_done_low", 32'(load_done), 32'h0);
    chk("body_busy_high", 32'(load_busy), 32'h1);
    cyc(1'b0, meas, 1'b0, 5'd0);
    chk("body_done", 32'(load_done), 32'h1);
    chk("body_mv", 32'(meas_valid), 32'h1);
    chk("body_busy_low", 32'(load_busy), 32'h0);
  endtask

  initial begin
    nom = '{24'h000000, 24'h0001EB, 24'h004000, 24'h000000, 24'h000000,
            24'h004000, 24'h004000, 24'h000666, 24'h000000, 24'h004000,
            24'h0000A3, 24'h000000, 24'h000000, 24'h0000A3, 24'h004000,
            24'h000000, 24'h000666, 24'h000000, 24'h000000, 24'h000000};
    tbl[0] = mkv(1'b1, 24'h0, 1'b0, 5'd0, 1'b1, 24'h0, 1'b0, 1'b0, 24'h0, 1'b1);
    for (int i = 1; i <= 20; i++)
      tbl[i] = mkv(1'b0, nom[i-1], 1'b0, 5'd0, 1'b0, 24'h0, 1'b0, 1'b0, 24'h0, 1'b1);
    tbl[21] = mkv(1'b0, 24'h002000, 1'b0, 5'd0, 1'b0, 24'h0, 1'b1, 1'b1, 24'h002000, 1'b0);
    tbl[22] = mkv(1'b0, 24'h0, 1'b0, 5'd1, 1'b1, 24'h0001EB, 1'b1, 1'b0, 24'h002000, 1'b0);
    tbl[23] = mkv(1'b0, 24'h0, 1'b0, 5'd7, 1'b1, 24'h000666, 1'b1, 1'b0, 24'h002000, 1'b0);
    tbl[24] = mkv(1'b0, 24'h0, 1'b0, 5'd16, 1'b1, 24'h000666, 1'b1, 1'b0, 24'h002000, 1'b0);
    tbl[25] = mkv(1'b0, 24'h0, 1'b0, 5'd25, 1'b1, 24'h000000, 1'b1, 1'b0, 24'h002000, 1'b0);
    tbl[26] = mkv(1'b0, 24'h0, 1'b0, 5'd2, 1'b1, 24'h004000, 1'b1, 1'b0, 24'h002000, 1'b0);

    do_reset();

    // Idle: measurement requests ignored, out-of-range address reads 0
    cyc(1'b0, 24'h001234, 1'b1, 5'd25);
    chk("idle_mv", 32'(meas_valid), 32'h0);
    chk("idle_coef25", 32'(coef_data), 32'h0);

    run_table();

    // Back-to-back measurements with sign conversion
    cyc(1'b0, 24'h000100, 1'b1, 5'd0);
    chk("st0_mv", 32'(meas_valid), 32'h1); chk("st0_data", 32'(meas_data), 32'h000100);
    cyc(1'b0, 24'h800100, 1'b1, 5'd0);
    chk("st1_mv", 32'(meas_valid), 32'h1); chk("st1_data", 32'(meas_data), 32'hFFFF00);
    cyc(1'b0, 24'h000200, 1'b1, 5'd0);
    chk("st2_mv", 32'(meas_valid), 32'h1); chk("st2_data", 32'(meas_data), 32'h000200);
    cyc(1'b0, 24'h000300, 1'b0, 5'd0);
    chk("st3_mv", 32'(meas_valid), 32'h0); chk("st3_data", 32'(meas_data), 32'h000200);

    // START in RUN with a simultaneous meas_take, then word0 = -0.5
    cyc(1'b1, 24'h000123, 1'b1, 5'd0);
    chk("run_start_done", 32'(load_done), 32'h0);
    chk("run_start_mv", 32'(meas_valid), 32'h0);
    chk("run_start_busy", 32'(load_busy), 32'h1);
    for (int i = 0; i < 20; i++) ws[i] = 24'h0;
    ws[0] = 24'h802000;
    load_body(24'h000010);
    cyc(1'b0, 24'h0, 1'b0, 5'd0);
    chk("sign_neg_coef0", 32'(coef_data), 32'hFFE000);

    // Negative zero
    cyc(1'b1, 24'h0, 1'b0, 5'd0);
    ws[0] = 24'h800000;
    load_body(24'h800000);
    chk("negzero_meas", 32'(meas_data), 32'h0);
    cyc(1'b0, 24'h0, 1'b0, 5'd0);
    chk("negzero_coef0", 32'(coef_data), 32'h0);

    // Restart after 10 words, then a full second set
    cyc(1'b1, 24'h0, 1'b0, 5'd0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 24'($urandom), 1'b0, 5'd0);
    cyc(1'b1, 24'h0, 1'b0, 5'd0);
    for (int i = 0; i < 20; i++) ws[i] = 24'($urandom);
    load_body(24'h002000);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 24'h0, 1'b0, 5'(i));
      chk($sformatf("restart_coef%0d", i), 32'(coef_data), 32'(ref_conv(ws[i])));
    end

    // Reset mid-load clears everything, then a nominal load works again
    cyc(1'b1, 24'h0, 1'b0, 5'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, nom[i] | 24'h000111, 1'b0, 5'd0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 24'h0, 1'b0, 5'(i));
      chk($sformatf("post_rst_coef%0d", i), 32'(coef_data), 32'h0);
    end
    run_table();

    // Random traffic against the reference model
    for (int n = 0; n < 4000; n++) begin
      logic [23:0] d;
      if ($urandom_range(0, 799) == 0) do_reset();
      d = ($urandom_range(0, 15) == 0) ? 24'h800000 : 24'($urandom);
      cyc($urandom_range(0, 39) == 0, d, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
